// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package mem_arb_pkg;

    // Arbiter sequencing: idle, data access, fetch access, one-cycle response
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Which CPU port owns the access currently in flight
    typedef enum logic {
        PORT_D = 1'b0,
        PORT_I = 1'b1
    } port_t;

    // Word returned on a timed-out read; all zeros is a MIPS NOP
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_wdog.sv
// Acknowledge watchdog: reloads when an access starts and counts down while
// the access waits for an acknowledge. Expired fires in the last allowed wait
// cycle, and only if no acknowledge arrives in that same cycle.
module mem_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic mack,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count;

            // Down-counter: reload on access start, step down per unacknowledged cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count <= '0;
                end else if (clear) begin
                    count <= LOAD;
                end else if (enable && !mack && (count != '0)) begin
                    count <= count - 1'b1;
                end
            end

            assign expired = enable && !mack && (count == '0);
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU fetch and data ports.
// The data port wins every tie because it belongs to the older instruction;
// Stall holds the pipeline until every request of this pipeline cycle is served.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Ireq,
    input  logic [ADDR_W-1:0] Iaddr,
    output logic [DATA_W-1:0] Inst,
    output logic              Ivalid,
    input  logic              Rmem,
    input  logic              Wmem,
    input  logic [ADDR_W-1:0] Daddr,
    input  logic [DATA_W-1:0] Dwrite,
    output logic [DATA_W-1:0] Dread,
    output logic              Dvalid,
    output logic              Stall,
    output logic              Mreq,
    output logic [ADDR_W-1:0] Maddr,
    output logic [DATA_W-1:0] Mwdata,
    output logic              Mwe,
    input  logic [DATA_W-1:0] Mrdata,
    input  logic              Mack,
    output logic              Err
);

    state_t state;
    state_t state_next;
    port_t  port_q;
    logic   wr_q;
    logic   d_done;
    logic   i_done;
    logic   d_pend;
    logic   d_issue;
    logic   i_issue;
    logic   in_acc;
    logic   expired;

    assign d_pend  = Rmem | Wmem;
    assign in_acc  = (state == D_ACC) || (state == I_ACC);
    assign d_issue = (state == IDLE) && d_pend && !d_done;
    assign i_issue = (state == IDLE) && !d_issue && Ireq && !i_done;
    assign Stall   = (d_pend && !(d_done || Dvalid)) || (Ireq && !(i_done || Ivalid));

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (Clk),
        .rst     (Clr),
        .clear   (d_issue | i_issue),
        .enable  (in_acc),
        .mack    (Mack),
        .expired (expired)
    );

    // State register
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: data before fetch, finish on acknowledge or watchdog expiry
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_issue) begin
                    state_next = D_ACC;
                end else if (i_issue) begin
                    state_next = I_ACC;
                end
            end
            D_ACC, I_ACC: begin
                if (Mack || expired) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; Mreq falls the moment reset forces IDLE
    always_comb begin
        Mreq   = in_acc;
        Mwe    = (state == D_ACC) && wr_q;
        Dvalid = (state == RESP) && (port_q == PORT_D);
        Ivalid = (state == RESP) && (port_q == PORT_I);
    end

    // Request latching, read capture, error reporting and served bookkeeping
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            Maddr  <= '0;
            Mwdata <= '0;
            wr_q   <= 1'b0;
            port_q <= PORT_D;
            Inst   <= '0;
            Dread  <= '0;
            Err    <= 1'b0;
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else begin
            if (d_issue) begin
                Maddr  <= Daddr;
                Mwdata <= Dwrite;
                wr_q   <= Wmem;
                port_q <= PORT_D;
            end else if (i_issue) begin
                Maddr  <= Iaddr;
                wr_q   <= 1'b0;
                port_q <= PORT_I;
            end

            if (in_acc) begin
                if (Mack) begin
                    if (!wr_q) begin
                        if (port_q == PORT_D) begin
                            Dread <= Mrdata;
                        end else begin
                            Inst <= Mrdata;
                        end
                    end
                end else if (expired) begin
                    Err <= 1'b1;
                    if (!wr_q) begin
                        if (port_q == PORT_D) begin
                            Dread <= ERR_DATA;
                        end else begin
                            Inst <= ERR_DATA;
                        end
                    end
                end
            end

            if (!Stall) begin
                d_done <= 1'b0;
                i_done <= 1'b0;
            end else begin
                if (Dvalid) begin
                    d_done <= 1'b1;
                end
                if (Ivalid) begin
                    i_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small acknowledge-delay memory model.
module tb_mem_port_arbiter;

    logic        Clk;
    logic        Clr;
    logic        Ireq;
    logic [31:0] Iaddr;
    logic [31:0] Inst;
    logic        Ivalid;
    logic        Rmem;
    logic        Wmem;
    logic [31:0] Daddr;
    logic [31:0] Dwrite;
    logic [31:0] Dread;
    logic        Dvalid;
    logic        Stall;
    logic        Mreq;
    logic [31:0] Maddr;
    logic [31:0] Mwdata;
    logic        Mwe;
    logic [31:0] Mrdata;
    logic        Mack;
    logic        Err;

    int          total;
    int          bad;
    bit          mem_on;
    int          ack_delay;
    int          wait_cnt;
    int          txn_count;
    int          txn_start;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    mem_port_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .TIMEOUT  (4),
        .ERR_DATA (32'h0000_0000)
    ) dut (
        .Clk    (Clk),
        .Clr    (Clr),
        .Ireq   (Ireq),
        .Iaddr  (Iaddr),
        .Inst   (Inst),
        .Ivalid (Ivalid),
        .Rmem   (Rmem),
        .Wmem   (Wmem),
        .Daddr  (Daddr),
        .Dwrite (Dwrite),
        .Dread  (Dread),
        .Dvalid (Dvalid),
        .Stall  (Stall),
        .Mreq   (Mreq),
        .Maddr  (Maddr),
        .Mwdata (Mwdata),
        .Mwe    (Mwe),
        .Mrdata (Mrdata),
        .Mack   (Mack),
        .Err    (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory contents seen by reads
    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        case (addr)
            32'h0000_0040: return 32'h2008_0005;
            32'h0000_0044: return 32'h0000_1111;
            32'h0000_0020: return 32'h1234_5678;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign Mack   = mem_on && Mreq && (wait_cnt == ack_delay);
    assign Mrdata = Mack ? mem_read(Maddr) : 32'hBAD0_BAD0;

    // Memory side: count wait cycles, completed transactions and last write
    always @(posedge Clk) begin
        if (Mreq && !Mack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (Mreq && Mack) begin
            txn_count <= txn_count + 1;
            if (Mwe) begin
                last_waddr <= Maddr;
                last_wdata <= Mwdata;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rmem, input logic wmem, input logic [31:0] daddr,
                                 input logic [31:0] dwrite, input logic ireq, input logic [31:0] iaddr);
        Rmem   = rmem;
        Wmem   = wmem;
        Daddr  = daddr;
        Dwrite = dwrite;
        Ireq   = ireq;
        Iaddr  = iaddr;
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        wait_cnt  = 0;
        txn_count = 0;
        mem_on    = 1'b1;
        ack_delay = 0;
        Clr       = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge Clk);
        checkOutput("rst_mreq", Mreq, 1'b0);
        checkOutput("rst_err", Err, 1'b0);
        Clr = 1'b0;
        tick();
        checkOutput("idle_mreq", Mreq, 1'b0);
        checkOutput("idle_inst", Inst, 32'h0);
        checkOutput("idle_dread", Dread, 32'h0);
        checkOutput("idle_maddr", Maddr, 32'h0);
        checkOutput("idle_stall", Stall, 1'b0);
        checkOutput("idle_valids", {Ivalid, Dvalid, Mwe}, 3'b000);

        // Asynchronous reset in the middle of a data access
        mem_on = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("midrst_mreq_before", Mreq, 1'b1);
        checkOutput("midrst_maddr_before", Maddr, 32'h30);
        #2 Clr = 1'b1;
        #1 checkOutput("midrst_mreq_async", Mreq, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge Clk);
        Clr = 1'b0;
        mem_on = 1'b1;
        tick();
        tick();
        checkOutput("midrst_mreq_after", Mreq, 1'b0);
        checkOutput("midrst_maddr_after", Maddr, 32'h0);
        checkOutput("midrst_stall_after", Stall, 1'b0);
        checkOutput("midrst_txn", txn_count, 0);

        // Single fetch with zero-wait memory
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        #1 checkOutput("fetch_stall_t", Stall, 1'b1);
        tick();
        checkOutput("fetch_mreq_t1", Mreq, 1'b1);
        checkOutput("fetch_maddr_t1", Maddr, 32'h40);
        checkOutput("fetch_mwe_t1", Mwe, 1'b0);
        checkOutput("fetch_stall_t1", Stall, 1'b1);
        tick();
        checkOutput("fetch_ivalid_t2", Ivalid, 1'b1);
        checkOutput("fetch_inst_t2", Inst, 32'h2008_0005);
        checkOutput("fetch_stall_t2", Stall, 1'b0);
        checkOutput("fetch_mreq_t2", Mreq, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("fetch_ivalid_t3", Ivalid, 1'b0);

        // Simultaneous store and fetch: store first, one transaction each
        txn_start = txn_count;
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b1, 32'h44);
        #1 checkOutput("both_stall_t", Stall, 1'b1);
        tick();
        checkOutput("both_mreq_t1", Mreq, 1'b1);
        checkOutput("both_mwe_t1", Mwe, 1'b1);
        checkOutput("both_maddr_t1", Maddr, 32'h10);
        checkOutput("both_mwdata_t1", Mwdata, 32'hCAFE_F00D);
        tick();
        checkOutput("both_dvalid_t2", Dvalid, 1'b1);
        checkOutput("both_stall_t2", Stall, 1'b1);
        checkOutput("both_dread_t2", Dread, 32'h0);
        tick();
        checkOutput("both_mreq_t3", Mreq, 1'b0);
        checkOutput("both_stall_t3", Stall, 1'b1);
        checkOutput("both_dvalid_t3", Dvalid, 1'b0);
        tick();
        checkOutput("both_mreq_t4", Mreq, 1'b1);
        checkOutput("both_maddr_t4", Maddr, 32'h44);
        checkOutput("both_mwe_t4", Mwe, 1'b0);
        checkOutput("both_stall_t4", Stall, 1'b1);
        tick();
        checkOutput("both_ivalid_t5", Ivalid, 1'b1);
        checkOutput("both_inst_t5", Inst, 32'h0000_1111);
        checkOutput("both_stall_t5", Stall, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("both_txn", txn_count - txn_start, 2);
        checkOutput("both_waddr", last_waddr, 32'h10);
        checkOutput("both_wdata", last_wdata, 32'hCAFE_F00D);

        // Load with three wait cycles; acknowledge lands on the watchdog's last cycle
        ack_delay = 3;
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        #1 checkOutput("slow_stall_t", Stall, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("slow_mreq_t%0d", i), Mreq, 1'b1);
            checkOutput($sformatf("slow_maddr_t%0d", i), Maddr, 32'h20);
            checkOutput($sformatf("slow_dvalid_t%0d", i), Dvalid, 1'b0);
        end
        tick();
        checkOutput("slow_dvalid_t5", Dvalid, 1'b1);
        checkOutput("slow_dread_t5", Dread, 32'h1234_5678);
        checkOutput("slow_stall_t5", Stall, 1'b0);
        checkOutput("slow_err_t5", Err, 1'b0);

        // Same read held into the next pipeline cycle is issued again
        ack_delay = 0;
        txn_start = txn_count;
        tick();
        checkOutput("rep_stall_t", Stall, 1'b1);
        checkOutput("rep_mreq_t", Mreq, 1'b0);
        tick();
        checkOutput("rep_mreq_t1", Mreq, 1'b1);
        checkOutput("rep_maddr_t1", Maddr, 32'h20);
        tick();
        checkOutput("rep_dvalid_t2", Dvalid, 1'b1);
        checkOutput("rep_stall_t2", Stall, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("rep_txn", txn_count - txn_start, 1);

        // Fetch that is never acknowledged: watchdog after four request cycles
        mem_on = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h48);
        #1 checkOutput("wd_stall_t", Stall, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("wd_mreq_t%0d", i), Mreq, 1'b1);
            checkOutput($sformatf("wd_err_t%0d", i), Err, 1'b0);
        end
        tick();
        checkOutput("wd_mreq_t5", Mreq, 1'b0);
        checkOutput("wd_err_t5", Err, 1'b1);
        checkOutput("wd_ivalid_t5", Ivalid, 1'b1);
        checkOutput("wd_inst_t5", Inst, 32'h0000_0000);
        checkOutput("wd_stall_t5", Stall, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checkOutput("wd_ivalid_t6", Ivalid, 1'b0);
        checkOutput("wd_err_sticky", Err, 1'b1);
        checkOutput("wd_mreq_t6", Mreq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
